// File: rtl/mem_dump_streamer_if.sv
// Beat stream carried from the dump engine to its consumer.
// The master drives valid/addr/data/last and the slave drives ready.
interface mem_dump_streamer_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 5
);
    logic             valid;
    logic             ready;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output addr, output data, output last, input ready);
    modport slave  (input valid, input addr, input data, input last, output ready);
endinterface

// File: rtl/mem_dump_streamer.sv
// Byte memory with a host load port and a dump engine that streams an
// inclusive, wrapping address window back out as (addr, data) beats.
//
// state | meaning
// IDLE  | no dump in progress, waiting for start
// BUSY  | a beat is presented on the stream, waiting for accept or abort
module mem_dump_streamer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [AW-1:0]    end_addr,
    input  logic             abort,
    mem_dump_streamer_if.master sif,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    beats_left;
    logic [AW-1:0]    next_addr;
    logic             accept;

    assign next_addr = sif.addr + AW'(1);
    assign accept    = sif.valid && sif.ready;

    // No reset on the array so its contents survive a mid-dump reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads sample mem before this edge's write lands, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sif.valid  <= 1'b0;
            sif.addr   <= '0;
            sif.data   <= '0;
            sif.last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beats_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= BUSY;
                        busy       <= 1'b1;
                        sif.valid  <= 1'b1;
                        sif.addr   <= start_addr;
                        sif.data   <= mem[start_addr];
                        sif.last   <= (start_addr == end_addr);
                        beats_left <= end_addr - start_addr;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sif.valid <= 1'b0;
                        sif.last  <= 1'b0;
                    end else if (accept) begin
                        if (sif.last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            sif.valid <= 1'b0;
                            sif.last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            sif.addr   <= next_addr;
                            sif.data   <= mem[next_addr];
                            beats_left <= beats_left - AW'(1);
                            sif.last   <= (beats_left == AW'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: load, windows, wrap, stall, abort,
// read/write race and reset with memory retention.
module tb_mem_dump_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [4:0] start_addr;
    logic [4:0] end_addr;
    logic       abort;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    logic [7:0] mdl [32];

    always #5 clk = ~clk;

    mem_dump_streamer_if #(.WIDTH(8), .AW(5)) sif ();

    mem_dump_streamer #(.WIDTH(8), .DEPTH(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .abort      (abort),
        .sif        (sif),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [4:0] a, input logic [7:0] d,
                            input logic l);
        chk({tag, "_valid"}, 32'(sif.valid), 32'd1);
        chk({tag, "_addr"},  32'(sif.addr),  32'(a));
        chk({tag, "_data"},  32'(sif.data),  32'(d));
        chk({tag, "_last"},  32'(sif.last),  32'(l));
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_done"},  32'(done),      32'd0);
    endtask

    task automatic chk_end(input string tag, input logic exp_done);
        chk({tag, "_end_valid"}, 32'(sif.valid), 32'd0);
        chk({tag, "_end_last"},  32'(sif.last),  32'd0);
        chk({tag, "_end_busy"},  32'(busy),      32'd0);
        chk({tag, "_end_done"},  32'(done),      32'(exp_done));
    endtask

    // Full-throughput dump; beats must appear on consecutive cycles.
    task automatic dump_check(input string tag, input logic [4:0] sa, input logic [4:0] ea,
                              input int n);
        logic [4:0] a;
        start = 1'b1; start_addr = sa; end_addr = ea; sif.ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            a = sa + 5'(k);
            chk_beat(tag, a, mdl[a], k == n - 1);
            tick();
        end
        chk_end(tag, 1'b1);
        tick();
        chk({tag, "_done_gone"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_addr = '0; end_addr = '0; abort = 1'b0;
        sif.ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(sif.valid), 32'd0);
        chk("rst_addr",  32'(sif.addr),  32'd0);
        chk("rst_data",  32'(sif.data),  32'd0);
        chk("rst_last",  32'(sif.last),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 8'(i + 8'h10);
            mdl[i] = 8'(i + 8'h10);
            tick();
        end
        wr_en = 1'b0;

        // Window 3..6: (3,13),(4,14),(5,15),(6,16)
        start = 1'b1; start_addr = 5'd3; end_addr = 5'd6; sif.ready = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("w36_b0", 5'd3, 8'h13, 1'b0); tick();
        chk_beat("w36_b1", 5'd4, 8'h14, 1'b0); tick();
        chk_beat("w36_b2", 5'd5, 8'h15, 1'b0); tick();
        chk_beat("w36_b3", 5'd6, 8'h16, 1'b1); tick();
        chk_end("w36", 1'b1);
        tick();
        chk("w36_done_once", 32'(done), 32'd0);

        // Wrap window 30..1 -> 30,31,0,1
        dump_check("wrap", 5'd30, 5'd1, 4);

        // Single beat 5..5 with stall; start while busy must be ignored
        start = 1'b1; start_addr = 5'd5; end_addr = 5'd5; sif.ready = 1'b0;
        tick();
        start = 1'b1; start_addr = 5'd9; end_addr = 5'd12;
        for (int k = 0; k < 3; k++) begin
            chk_beat("stall", 5'd5, 8'h15, 1'b1);
            tick();
        end
        start = 1'b0;
        chk_beat("stall_hold", 5'd5, 8'h15, 1'b1);
        sif.ready = 1'b1;
        tick();
        chk_end("stall", 1'b1);
        tick();
        chk("stall_done_once", 32'(done), 32'd0);

        // Abort after two accepts
        start = 1'b1; start_addr = 5'd0; end_addr = 5'd7; sif.ready = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("ab_b0", 5'd0, 8'h10, 1'b0); tick();
        chk_beat("ab_b1", 5'd1, 8'h11, 1'b0); tick();
        chk_beat("ab_b2", 5'd2, 8'h12, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_end("abort", 1'b0);
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        // start and abort together in IDLE: start wins
        start = 1'b1; abort = 1'b1; start_addr = 5'd2; end_addr = 5'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_beat("restart", 5'd2, 8'h12, 1'b1);
        tick();
        chk_end("restart", 1'b1);
        tick();

        // Write to addr 2 on the edge that loads beat 2: old data seen
        start = 1'b1; start_addr = 5'd0; end_addr = 5'd3; sif.ready = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("race_b0", 5'd0, 8'h10, 1'b0); tick();
        chk_beat("race_b1", 5'd1, 8'h11, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        mdl[2] = 8'hAA;
        chk_beat("race_b2", 5'd2, 8'h12, 1'b0); tick();
        chk_beat("race_b3", 5'd3, 8'h13, 1'b1); tick();
        chk_end("race", 1'b1);
        tick();
        dump_check("rerun", 5'd0, 5'd3, 4);
        chk("rerun_mdl2", 32'(mdl[2]), 32'hAA);

        // Reset mid-dump, then confirm memory retained
        start = 1'b1; start_addr = 5'd10; end_addr = 5'd20; sif.ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk_beat("pre_rst", 5'd12, 8'h1C, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 32'(sif.valid), 32'd0);
        chk("mrst_addr",  32'(sif.addr),  32'd0);
        chk("mrst_data",  32'(sif.data),  32'd0);
        chk("mrst_last",  32'(sif.last),  32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        chk("mrst_done",  32'(done),      32'd0);
        tick();
        chk("mrst_no_done", 32'(done), 32'd0);
        dump_check("keep_lo", 5'd0, 5'd15, 16);
        dump_check("keep_hi", 5'd16, 5'd31, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
